// File: rtl/umi_gpio_pkg.sv
// Shared constants for the UMI GPIO bridge: opcodes, cmd field positions and transfer sizing.
package umi_gpio_pkg;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_WRITE = 5'h04;
  localparam logic [4:0] REQ_POSTED = 5'h05;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 5;
  localparam int unsigned SIZE_LSB   = 5;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned LEN_LSB    = 8;
  localparam int unsigned LEN_W      = 8;

  localparam int unsigned OFFSET_W   = 16;
  localparam int unsigned SPACE_BIT  = 16;

  // Transfer length in bytes, clamped to one data beat.
  function automatic int unsigned xfer_bytes(input logic [SIZE_W-1:0] size,
                                             input logic [LEN_W-1:0]  len,
                                             input int unsigned       max_bytes);
    int unsigned b;
    b = (32'(len) + 32'd1) << size;
    return (b > max_bytes) ? max_bytes : b;
  endfunction

endpackage

// File: rtl/umi_gpio_bytesel.sv
// Extracts nbytes bytes of vec starting at byte offset into lane 0 upward; all other lanes
// and any bytes past the end of vec read as zero.
module umi_gpio_bytesel
  import umi_gpio_pkg::*;
#(
  parameter int unsigned VW = 384,
  parameter int unsigned DW = 256
) (
  input  logic [VW-1:0]          vec,
  input  logic [OFFSET_W-1:0]    offset,
  input  logic [$clog2(DW/8):0]  nbytes,
  output logic [DW-1:0]          data
);

  localparam int unsigned XW = (VW > DW) ? VW : DW;

  logic [XW-1:0] shifted;
  logic          unused_shifted;

  // Shifting past the top of vec naturally zero-fills out-of-range bytes.
  always_comb begin
    shifted = XW'(vec) >> {offset, 3'b000};
    data    = '0;
    for (int i = 0; i < DW / 8; i++) begin
      data[8*i +: 8] = (i < int'(nbytes)) ? shifted[8*i +: 8] : 8'h00;
    end
  end

  assign unused_shifted = ^shifted;

endmodule

// File: rtl/umi_gpio_core.sv
// UMI device endpoint driving a registered GPIO output bank and sampling a GPIO input bank.
// Define UMI_GPIO_OUT_READBACK_EN to let reads with dstaddr[16]=1 return gpio_out.
module umi_gpio_core
  import umi_gpio_pkg::*;
#(
  parameter int unsigned DW     = 256,
  parameter int unsigned AW     = 64,
  parameter int unsigned CW     = 32,
  parameter int unsigned IWIDTH = 384,
  parameter int unsigned OWIDTH = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              udev_req_valid,
  output logic              udev_req_ready,
  input  logic [CW-1:0]     udev_req_cmd,
  input  logic [AW-1:0]     udev_req_dstaddr,
  input  logic [AW-1:0]     udev_req_srcaddr,
  input  logic [DW-1:0]     udev_req_data,
  output logic              udev_resp_valid,
  input  logic              udev_resp_ready,
  output logic [CW-1:0]     udev_resp_cmd,
  output logic [AW-1:0]     udev_resp_dstaddr,
  output logic [AW-1:0]     udev_resp_srcaddr,
  output logic [DW-1:0]     udev_resp_data,
  input  logic [IWIDTH-1:0] gpio_in,
  output logic [OWIDTH-1:0] gpio_out
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned NW = $clog2(NB) + 1;
  localparam int unsigned WW = (OWIDTH > DW) ? OWIDTH : DW;
  localparam int unsigned BW = (OWIDTH / 8 > NB) ? OWIDTH / 8 : NB;

  logic [OPCODE_W-1:0] opcode;
  logic [OFFSET_W-1:0] offset;
  logic [NW-1:0]       nbytes;
  logic                accept, is_read, is_write, is_posted;
  logic [DW-1:0]       rd_data;

  assign opcode    = udev_req_cmd[OPCODE_LSB +: OPCODE_W];
  assign offset    = udev_req_dstaddr[OFFSET_W-1:0];
  assign nbytes    = NW'(xfer_bytes(udev_req_cmd[SIZE_LSB +: SIZE_W],
                                    udev_req_cmd[LEN_LSB +: LEN_W], NB));
  assign is_read   = (opcode == REQ_READ);
  assign is_write  = (opcode == REQ_WRITE);
  assign is_posted = (opcode == REQ_POSTED);

  // One-entry response register: a new request may land as the old response drains.
  assign udev_req_ready = !udev_resp_valid || udev_resp_ready;
  assign accept         = udev_req_valid && udev_req_ready;

  logic [DW-1:0] in_data;

  umi_gpio_bytesel #(.VW(IWIDTH), .DW(DW)) u_sel_in (
    .vec    (gpio_in),
    .offset (offset),
    .nbytes (nbytes),
    .data   (in_data)
  );

`ifdef UMI_GPIO_OUT_READBACK_EN
  logic [DW-1:0] out_data;

  umi_gpio_bytesel #(.VW(OWIDTH), .DW(DW)) u_sel_out (
    .vec    (gpio_out),
    .offset (offset),
    .nbytes (nbytes),
    .data   (out_data)
  );

  assign rd_data = udev_req_dstaddr[SPACE_BIT] ? out_data : in_data;
`else
  assign rd_data = in_data;
`endif

  // Write merge: lane-aligned data and byte mask shifted up to the GPIO byte offset.
  logic [NB-1:0]     lane_mask;
  logic [BW-1:0]     bmask_wide;
  logic [WW-1:0]     wdata_wide;
  logic [OWIDTH-1:0] wmask, wdata, gpio_out_d;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < int'(NB); i++) begin
      lane_mask[i] = (i < int'(nbytes));
    end
    bmask_wide = BW'(lane_mask) << offset;
    wdata_wide = WW'(udev_req_data) << {offset, 3'b000};
    wdata      = wdata_wide[OWIDTH-1:0];
    wmask      = '0;
    for (int j = 0; j < int'(OWIDTH / 8); j++) begin
      wmask[8*j +: 8] = {8{bmask_wide[j]}};
    end
    gpio_out_d = (gpio_out & ~wmask) | (wdata & wmask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out          <= '0;
      udev_resp_valid   <= 1'b0;
      udev_resp_cmd     <= '0;
      udev_resp_dstaddr <= '0;
      udev_resp_srcaddr <= '0;
      udev_resp_data    <= '0;
    end else begin
      if (accept && (is_write || is_posted)) begin
        gpio_out <= gpio_out_d;
      end
      if (accept && (is_read || is_write)) begin
        udev_resp_valid   <= 1'b1;
        udev_resp_cmd     <= {udev_req_cmd[CW-1:OPCODE_W], is_read ? RESP_READ : RESP_WRITE};
        udev_resp_dstaddr <= udev_req_srcaddr;
        udev_resp_srcaddr <= udev_req_dstaddr;
        udev_resp_data    <= is_read ? rd_data : '0;
      end else if (udev_resp_ready) begin
        udev_resp_valid <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{udev_req_dstaddr[AW-1:OFFSET_W], wdata_wide, bmask_wide};

endmodule

// File: tb/tb_umi_gpio_core.sv
// Directed bench for umi_gpio_core with a loopback harness on the GPIO pins.
module tb_umi_gpio_core;

  localparam int DW = 256;
  localparam int AW = 64;
  localparam int CW = 32;
  localparam int IW = 384;
  localparam int OW = 128;

  localparam logic [127:0] P    = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [15:0]  UPPR = 16'hA5C3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [CW-1:0] req_cmd;
  logic [AW-1:0] req_dst, req_src;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_ready;
  logic [CW-1:0] resp_cmd;
  logic [AW-1:0] resp_dst, resp_src;
  logic [DW-1:0] resp_data;
  logic [IW-1:0] gpio_in;
  logic [OW-1:0] gpio_out;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] cap_cmd;
  logic [AW-1:0] cap_dst, cap_src;
  logic [DW-1:0] cap_data;
  int            cnt;

  always #5 clk = ~clk;

  assign gpio_in = {~gpio_out, gpio_out, 112'h0, gpio_out[15:8] - 8'd34, gpio_out[7:0] + 8'd12};

  umi_gpio_core #(.DW(DW), .AW(AW), .CW(CW), .IWIDTH(IW), .OWIDTH(OW)) dut (
    .clk               (clk),
    .reset             (reset),
    .udev_req_valid    (req_valid),
    .udev_req_ready    (req_ready),
    .udev_req_cmd      (req_cmd),
    .udev_req_dstaddr  (req_dst),
    .udev_req_srcaddr  (req_src),
    .udev_req_data     (req_data),
    .udev_resp_valid   (resp_valid),
    .udev_resp_ready   (resp_ready),
    .udev_resp_cmd     (resp_cmd),
    .udev_resp_dstaddr (resp_dst),
    .udev_resp_srcaddr (resp_src),
    .udev_resp_data    (resp_data),
    .gpio_in           (gpio_in),
    .gpio_out          (gpio_out)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] size,
                                     input logic [7:0] len);
    return {UPPR, len, size, op};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Presents one request and returns 1ns after the edge that accepted it.
  task automatic send(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src,
                      input logic [255:0] data);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_dst   = dst;
    req_src   = src;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", {255'b0, req_ready}, 256'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_resp();
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("resp_arrives", {255'b0, resp_valid}, 256'd1);
    cap_cmd  = resp_cmd;
    cap_dst  = resp_dst;
    cap_src  = resp_src;
    cap_data = resp_data;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_cmd    = '0;
    req_dst    = '0;
    req_src    = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_cmd", resp_cmd, 0);
    reset = 1'b0;
    chk("rst_req_ready", req_ready, 1);

    // Byte 0 loopback +12
    send(mk(5'h03, 3'd0, 8'd0), 64'h0, 64'h1234, 256'h05);
    chk("wr0_gpio_out", gpio_out[7:0], 8'h05);
    get_resp();
    chk("wr0_resp_cmd", cap_cmd, {UPPR, 8'd0, 3'd0, 5'h04});
    chk("wr0_resp_data", cap_data, 0);
    send(mk(5'h01, 3'd0, 8'd0), 64'h0000_00AB_0000_0000, 64'h55, '0);
    get_resp();
    chk("rd0_resp_cmd", cap_cmd, {UPPR, 8'd0, 3'd0, 5'h02});
    chk("rd0_resp_data", cap_data, 256'h11);
    chk("rd0_resp_dst", cap_dst, 64'h55);
    chk("rd0_resp_src", cap_src, 64'h0000_00AB_0000_0000);

    // Byte 1 loopback -34
    send(mk(5'h03, 3'd0, 8'd0), 64'h1, 64'h0, 256'h40);
    get_resp();
    chk("wr1_gpio_out", gpio_out[15:0], 16'h4005);
    send(mk(5'h01, 3'd0, 8'd0), 64'h1, 64'h0, '0);
    get_resp();
    chk("rd1_resp_data", cap_data, 256'h1E);

    // 16-byte pattern and upper-bank reads
    send(mk(5'h03, 3'd0, 8'd15), 64'h0, 64'h0, {128'hDEAD, P});
    get_resp();
    chk("wr16_gpio_out", gpio_out, P);
    send(mk(5'h01, 3'd0, 8'd15), 64'h10, 64'h0, '0);
    get_resp();
    chk("rd16_resp_data", cap_data, {128'h0, P});
    chk("rd16_resp_cmd", cap_cmd, {UPPR, 8'd15, 3'd0, 5'h02});
    send(mk(5'h01, 3'd4, 8'd0), 64'h20, 64'h0, '0);
    get_resp();
    chk("rd32_resp_data", cap_data, {128'h0, ~P});
    send(mk(5'h01, 3'd0, 8'd15), 64'h28, 64'h0, '0);
    get_resp();
    chk("rd40_resp_data", cap_data, {192'h0, 64'hFEDCBA9876543210});
    send(mk(5'h01, 3'd4, 8'd0), 64'h1_0010, 64'h0, '0);
    get_resp();
    chk("rd_bit16_ignored", cap_data, {128'h0, P});

    // Posted write: no response; plain write: exactly one
    send(mk(5'h05, 3'd0, 8'd0), 64'h2, 64'h0, 256'hAA);
    chk("posted_gpio_out", gpio_out[23:16], 8'hAA);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("posted_no_resp", cnt, 0);
    send(mk(5'h03, 3'd0, 8'd0), 64'h2, 64'h0, 256'hAA);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("write_one_resp", cnt, 1);

    // Backpressure: response held stable, then handshake and new accept on one edge
    resp_ready = 1'b0;
    send(mk(5'h01, 3'd0, 8'd0), 64'h10, 64'h0, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1);
      chk("stall_data", resp_data, 256'h10);
      chk("stall_req_ready", req_ready, 0);
    end
    req_valid  = 1'b1;
    req_cmd    = mk(5'h03, 3'd0, 8'd0);
    req_dst    = 64'h3;
    req_data   = 256'h77;
    resp_ready = 1'b1;
    #1 chk("release_req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("release_gpio_out", gpio_out[31:24], 8'h77);
    chk("release_resp_valid", resp_valid, 1);
    chk("release_resp_op", resp_cmd[4:0], 5'h04);
    @(negedge clk);

    // Unknown opcode: dropped without response or state change
    send(mk(5'h07, 3'd0, 8'd0), 64'h0, 64'h0, 256'hFF);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("bad_op_no_resp", cnt, 0);
    chk("bad_op_gpio_out", gpio_out, 128'h0123456789ABCDEF_FEDCBA98_77AA3210);

    // Reset with a response pending
    resp_ready = 1'b0;
    send(mk(5'h01, 3'd0, 8'd0), 64'h0, 64'h0, '0);
    @(negedge clk);
    chk("pre_reset_pending", resp_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_gpio_out", gpio_out, 0);
    reset      = 1'b0;
    resp_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
